// File: rtl/sdram_req_scheduler_pkg.sv
// sdram_req_scheduler_pkg: shared state encoding, request layout and widths for the SDRAM host front end
package sdram_req_scheduler_pkg;
  localparam int HADDR_W = 24;
  localparam int DATA_W  = 16;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACTIVE} state_t;
  typedef struct packed {
    logic              we;
    logic [HADDR_W-1:0] addr;
    logic [DATA_W-1:0]  wdata;
  } req_t;
endpackage

// File: rtl/sdram_req_scheduler_fifo.sv
// sdram_req_fifo: in-order request FIFO with full/empty flags
// Ports: clk, rst_n (async active-low), i_push/i_data write side,
//        i_pop/o_data read side (o_data shows the head), o_full, o_empty.
module sdram_req_fifo #(
  parameter int W     = 41,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_push, w_pop;
  assign w_pop   = i_pop & ~o_empty;
  // a pop frees a slot in the same cycle, so a full FIFO may still take a push
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_data  = r_mem[r_rptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= i_data;
endmodule

// File: rtl/sdram_req_scheduler.sv
// sdram_req_scheduler: buffers host requests and issues them one at a time to the SDRAM controller
// Ports: clk, rst_n (async active-low);
//   host:  i_req_valid/o_req_ready/i_req_we/i_req_addr/i_req_wdata,
//          o_rsp_valid/o_rsp_rdata (read return), o_wr_done, o_timeout_err (sticky);
//   ctrl:  o_ctrl_wr_enable/o_ctrl_rd_enable/o_ctrl_wr_addr/o_ctrl_rd_addr/o_ctrl_wr_data,
//          i_ctrl_rd_data/i_ctrl_rd_ready/i_ctrl_busy.
module sdram_req_scheduler
  import sdram_req_scheduler_pkg::*;
#(
  parameter int HADDR_WIDTH   = HADDR_W,
  parameter int DATA_WIDTH    = DATA_W,
  parameter int FIFO_DEPTH    = 4,
  parameter int ISSUE_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_we,
  input  logic [HADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0]  i_req_wdata,
  output logic                   o_rsp_valid,
  output logic [DATA_WIDTH-1:0]  o_rsp_rdata,
  output logic                   o_wr_done,
  output logic                   o_timeout_err,
  output logic                   o_ctrl_wr_enable,
  output logic                   o_ctrl_rd_enable,
  output logic [HADDR_WIDTH-1:0] o_ctrl_wr_addr,
  output logic [HADDR_WIDTH-1:0] o_ctrl_rd_addr,
  output logic [DATA_WIDTH-1:0]  o_ctrl_wr_data,
  input  logic [DATA_WIDTH-1:0]  i_ctrl_rd_data,
  input  logic                   i_ctrl_rd_ready,
  input  logic                   i_ctrl_busy
);
  localparam int RW = 1 + HADDR_WIDTH + DATA_WIDTH;
  localparam int TW = $clog2(ISSUE_TIMEOUT + 1);
  state_t                 r_state, w_next;
  logic                   w_full, w_empty, w_pop, w_done, w_tmo, w_capture;
  logic [RW-1:0]          w_head;
  logic                   r_we, r_rd_seen, r_err;
  logic [HADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]  r_wdata, r_rdata;
  logic [TW-1:0]          r_tcnt;
  sdram_req_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (i_req_valid & ~w_full),
    .i_pop   (w_pop),
    .i_data  ({i_req_we, i_req_addr, i_req_wdata}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE:   if (!w_empty && !i_ctrl_busy) begin
                  w_next = S_ISSUE;
                  w_pop  = 1'b1;
                end
      S_ISSUE:  w_next = i_ctrl_busy ? S_ACTIVE : S_ISSUE;
      S_ACTIVE: if (!i_ctrl_busy) begin
                  w_next = S_IDLE;
                  w_done = 1'b1;
                end
      default:  w_next = S_IDLE;
    endcase
  end
  // the counter saturates one short of the limit so the flag condition stays true while retrying
  assign w_tmo     = (r_state == S_ISSUE) && (r_tcnt == TW'(ISSUE_TIMEOUT - 1));
  // rd_ready can coincide with the first busy cycle, which is still seen in S_ISSUE
  assign w_capture = (r_state != S_IDLE) && !r_we && i_ctrl_rd_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_rd_seen <= 1'b0;
      r_tcnt    <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_pop) begin
        {r_we, r_addr, r_wdata} <= w_head;
        r_rd_seen <= 1'b0;
        r_tcnt    <= '0;
      end else if (r_state == S_ISSUE && !w_tmo) r_tcnt <= r_tcnt + TW'(1);
      if (w_capture) begin
        r_rdata   <= i_ctrl_rd_data;
        r_rd_seen <= 1'b1;
      end
      if (w_tmo || (w_done && !r_we && !r_rd_seen)) r_err <= 1'b1;
    end
  // enables and pulses decode the async-reset state so they drop the moment rst_n falls
  assign o_ctrl_wr_enable = (r_state == S_ISSUE) && r_we;
  assign o_ctrl_rd_enable = (r_state == S_ISSUE) && !r_we;
  assign o_ctrl_wr_addr   = r_addr;
  assign o_ctrl_rd_addr   = r_addr;
  assign o_ctrl_wr_data   = r_wdata;
  assign o_req_ready      = ~w_full;
  assign o_rsp_valid      = w_done && !r_we && r_rd_seen;
  assign o_rsp_rdata      = r_rdata;
  assign o_wr_done        = w_done && r_we;
  assign o_timeout_err    = r_err;
endmodule

// File: tb/tb_sdram_req_scheduler.sv
// tb_sdram_req_scheduler: directed checks of the scheduler against a small SDRAM controller model
module tb_sdram_req_scheduler;
  import sdram_req_scheduler_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_req_valid = 1'b0, i_req_we = 1'b0;
  logic [23:0] i_req_addr = '0;
  logic [15:0] i_req_wdata = '0;
  logic        o_req_ready, o_rsp_valid, o_wr_done, o_timeout_err;
  logic [15:0] o_rsp_rdata, o_ctrl_wr_data;
  logic        o_ctrl_wr_enable, o_ctrl_rd_enable;
  logic [23:0] o_ctrl_wr_addr, o_ctrl_rd_addr;
  logic        m_refresh = 1'b0, m_force = 1'b0, m_busy, m_rdy, m_we;
  logic [15:0] m_rdata = '0, m_data;
  logic [23:0] m_addr;
  int          m_phase;
  logic [15:0] mem [logic [23:0]];
  logic [23:0] acc_q [$];
  int          n_acc = 0, n_wen = 0, n_ren = 0, n_wd = 0, n_rsp = 0, n_uns = 0, n_both = 0;
  logic        prev_en = 1'b0;
  logic [39:0] prev_bus = '0;
  int          total = 0, bad = 0;
  always #5 clk = ~clk;
  sdram_req_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_wr_done(o_wr_done),
    .o_timeout_err(o_timeout_err),
    .o_ctrl_wr_enable(o_ctrl_wr_enable), .o_ctrl_rd_enable(o_ctrl_rd_enable),
    .o_ctrl_wr_addr(o_ctrl_wr_addr), .o_ctrl_rd_addr(o_ctrl_rd_addr),
    .o_ctrl_wr_data(o_ctrl_wr_data), .i_ctrl_rd_data(m_rdata),
    .i_ctrl_rd_ready(m_rdy), .i_ctrl_busy(m_busy | m_force)
  );
  // controller model: samples enable only when idle and not refreshing, busy 2 cycles later;
  // reads: busy+rd_ready for one cycle; writes: busy for two cycles
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_phase <= 0;
      m_busy  <= 1'b0;
      m_rdy   <= 1'b0;
    end else
      case (m_phase)
        0: if (!m_refresh && (o_ctrl_wr_enable || o_ctrl_rd_enable)) begin
             m_phase <= 1;
             m_we    <= o_ctrl_wr_enable;
             m_addr  <= o_ctrl_wr_enable ? o_ctrl_wr_addr : o_ctrl_rd_addr;
             m_data  <= o_ctrl_wr_data;
             n_acc   <= n_acc + 1;
             acc_q.push_back(o_ctrl_wr_enable ? o_ctrl_wr_addr : o_ctrl_rd_addr);
           end
        1: begin
             m_phase <= 2;
             m_busy  <= 1'b1;
             m_rdy   <= !m_we;
             m_rdata <= mem.exists(m_addr) ? mem[m_addr] : 16'h0;
           end
        2: begin
             m_rdy   <= 1'b0;
             m_phase <= m_we ? 3 : 0;
             if (!m_we) m_busy <= 1'b0;
           end
        default: begin
             m_busy  <= 1'b0;
             mem[m_addr] = m_data;
             m_phase <= 0;
           end
      endcase
  always @(negedge clk) begin
    if (o_ctrl_wr_enable) n_wen++;
    if (o_ctrl_rd_enable) n_ren++;
    if (o_ctrl_wr_enable && o_ctrl_rd_enable) n_both++;
    if (o_wr_done) n_wd++;
    if (o_rsp_valid) n_rsp++;
    if ((o_ctrl_wr_enable || o_ctrl_rd_enable) && prev_en && {o_ctrl_wr_addr, o_ctrl_wr_data} != prev_bus) n_uns++;
    prev_en  = o_ctrl_wr_enable || o_ctrl_rd_enable;
    prev_bus = {o_ctrl_wr_addr, o_ctrl_wr_data};
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic push(input req_t r);
    int n = 0;
    i_req_valid = 1'b1;
    i_req_we    = r.we;
    i_req_addr  = r.addr;
    i_req_wdata = r.wdata;
    while (!o_req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 32'(o_req_ready), 1);
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask
  task automatic wait_wd(input int target, input string tag);
    int n = 0;
    while (n_wd < target && n < 400) begin
      @(posedge clk);
      n++;
    end
    check(tag, 32'(n_wd >= target), 1);
  endtask
  task automatic wait_rsp(input int target, input string tag);
    int n = 0;
    while (n_rsp < target && n < 400) begin
      @(posedge clk);
      n++;
    end
    check(tag, 32'(n_rsp >= target), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  initial begin
    int b_wen, b_ren, b_wd, b_rsp, b_acc, k, n;
    req_t vec [5];
    vec = '{'{1'b1, 24'h000100, 16'h00A0}, '{1'b1, 24'h000101, 16'h00A1},
            '{1'b1, 24'h000102, 16'h00A2}, '{1'b1, 24'h000103, 16'h00A3},
            '{1'b0, 24'h000100, 16'h0000}};
    idle(3);
    check("rst_ready", 32'(o_req_ready), 1);
    check("rst_rsp_valid", 32'(o_rsp_valid), 0);
    check("rst_wr_done", 32'(o_wr_done), 0);
    check("rst_err", 32'(o_timeout_err), 0);
    check("rst_enables", {30'b0, o_ctrl_wr_enable, o_ctrl_rd_enable}, 0);
    check("rst_addr", 32'(o_ctrl_wr_addr), 0);
    check("rst_rdata", 32'(o_rsp_rdata), 0);
    rst_n = 1'b1;
    idle(1);
    // single write
    b_wen = n_wen; b_ren = n_ren; b_wd = n_wd;
    push('{1'b1, 24'h000123, 16'hBEEF});
    wait_wd(b_wd + 1, "t1_wait");
    idle(3);
    check("t1_wr_done", 32'(n_wd - b_wd), 1);
    check("t1_wen_cycles", 32'(n_wen - b_wen), 3);
    check("t1_ren_cycles", 32'(n_ren - b_ren), 0);
    check("t1_acc_addr", 32'(acc_q[acc_q.size() - 1]), 32'h123);
    check("t1_mem", 32'(mem[24'h000123]), 32'hBEEF);
    check("t1_stable", 32'(n_uns), 0);
    // single read of the same location
    b_ren = n_ren; b_rsp = n_rsp;
    push('{1'b0, 24'h000123, 16'h0000});
    wait_rsp(b_rsp + 1, "t2_wait");
    idle(3);
    check("t2_rsp_cycles", 32'(n_rsp - b_rsp), 1);
    check("t2_rdata", 32'(o_rsp_rdata), 32'hBEEF);
    check("t2_ren_cycles", 32'(n_ren - b_ren), 3);
    check("t2_err", 32'(o_timeout_err), 0);
    // refresh stall stretches the issue phase
    m_refresh = 1'b1;
    b_wen = n_wen; b_wd = n_wd; b_acc = n_acc;
    push('{1'b1, 24'h000456, 16'h1234});
    idle(20);
    check("t3_held", 32'(o_ctrl_wr_enable), 1);
    check("t3_no_accept", 32'(n_acc - b_acc), 0);
    m_refresh = 1'b0;
    wait_wd(b_wd + 1, "t3_wait");
    idle(3);
    check("t3_hold_cycles", 32'((n_wen - b_wen) >= 22), 1);
    check("t3_mem", 32'(mem[24'h000456]), 32'h1234);
    check("t3_err", 32'(o_timeout_err), 0);
    // fill the FIFO while the controller looks busy
    m_force = 1'b1;
    b_wd = n_wd; b_rsp = n_rsp; b_acc = n_acc;
    for (int i = 0; i < 4; i++) push(vec[i]);
    check("t4_full_ready", 32'(o_req_ready), 0);
    i_req_valid = 1'b1; i_req_we = vec[4].we; i_req_addr = vec[4].addr; i_req_wdata = vec[4].wdata;
    idle(3);
    check("t4_still_full", 32'(o_req_ready), 0);
    check("t4_no_issue", 32'(n_acc - b_acc), 0);
    m_force = 1'b0;
    n = 0;
    while (!o_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_ready_after_pop", 32'(o_req_ready), 1);
    @(negedge clk);
    i_req_valid = 1'b0;
    wait_wd(b_wd + 4, "t4_wait_wr");
    wait_rsp(b_rsp + 1, "t4_wait_rd");
    idle(3);
    check("t4_accepts", 32'(n_acc - b_acc), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t4_order%0d", i), 32'(acc_q[acc_q.size() - 5 + i]), 32'(vec[i].addr));
    check("t4_rdata", 32'(o_rsp_rdata), 32'h00A0);
    // controller never accepts: timeout after 64 issue cycles, sticky
    m_refresh = 1'b1;
    b_wd = n_wd;
    push('{1'b1, 24'h000777, 16'h5555});
    k = 0; n = 0;
    while (k < 64 && n < 300) begin
      @(negedge clk);
      n++;
      if (o_ctrl_wr_enable) k++;
    end
    check("t5_issue_cycles", 32'(k), 64);
    check("t5_err_before", 32'(o_timeout_err), 0);
    @(negedge clk);
    check("t5_err_set", 32'(o_timeout_err), 1);
    idle(10);
    check("t5_err_sticky", 32'(o_timeout_err), 1);
    check("t5_retrying", 32'(o_ctrl_wr_enable), 1);
    m_refresh = 1'b0;
    wait_wd(b_wd + 1, "t5_wait");
    idle(2);
    check("t5_err_after", 32'(o_timeout_err), 1);
    // reset while a write is active with more requests queued
    b_wd = n_wd;
    push('{1'b1, 24'h000888, 16'h0001});
    push('{1'b1, 24'h000889, 16'h0002});
    push('{1'b1, 24'h00088A, 16'h0003});
    n = 0;
    while (!(m_busy && !o_ctrl_wr_enable) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_active", 32'(m_busy && !o_ctrl_wr_enable), 1);
    b_acc = n_acc;
    rst_n = 1'b0;
    #1;
    check("t6_enables", {30'b0, o_ctrl_wr_enable, o_ctrl_rd_enable}, 0);
    check("t6_pulses", {30'b0, o_rsp_valid, o_wr_done}, 0);
    check("t6_ready", 32'(o_req_ready), 1);
    check("t6_err_clr", 32'(o_timeout_err), 0);
    check("t6_addr_clr", 32'(o_ctrl_wr_addr), 0);
    idle(2);
    rst_n = 1'b1;
    idle(15);
    check("t6_discarded", 32'(n_acc - b_acc), 0);
    check("t6_no_done", 32'(n_wd - b_wd), 0);
    check("t6_ready_after", 32'(o_req_ready), 1);
    check("both_enables", 32'(n_both), 0);
    check("addr_stable", 32'(n_uns), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
